// File: rtl/forwarding_scoreboard_pkg.sv
// ============================================================================
// Package  : forwarding_scoreboard_pkg
// Brief    : Shared select encodings, stage tag type and helpers for the
//            operand forwarding scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package forwarding_scoreboard_pkg;

    // Tags hold register numbers zero-extended to this width; REG_AW must not exceed it.
    localparam int REG_AW_MAX = 8;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    localparam logic [REG_AW_MAX-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  load;
    } stage_tag_t;

    localparam stage_tag_t TAG_EMPTY = '{valid: 1'b0, rd: REG_ZERO, load: 1'b0};

    function automatic logic tag_match(input stage_tag_t tag, input logic [REG_AW_MAX-1:0] src);
        return tag.valid && (tag.rd == src);
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/forwarding_scoreboard_fwd_src_resolve.sv
// ============================================================================
// Module   : fwd_src_resolve
// Brief    : Single-operand comparator, youngest-producer priority and data
//            mux; flags a load-use hazard against the EX slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_src_resolve
    import forwarding_scoreboard_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [REG_AW_MAX-1:0] src,
    input  logic                  src_used,
    input  stage_tag_t            ex_tag,
    input  stage_tag_t            mem_tag,
    input  stage_tag_t            wb_tag,
    input  logic [DATA_W-1:0]     rf_data,
    input  logic [DATA_W-1:0]     ex_data,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [1:0]            sel,
    output logic [DATA_W-1:0]     data,
    output logic                  load_hazard
);

    logic w_live;
    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;
    logic w_unused_loads;

    assign w_live    = src_used && (src != REG_ZERO);
    assign w_hit_ex  = w_live && tag_match(ex_tag,  src);
    assign w_hit_mem = w_live && tag_match(mem_tag, src);
    assign w_hit_wb  = w_live && tag_match(wb_tag,  src);

    // Only a load still in EX lacks its data; MEM and WB loads forward normally.
    assign load_hazard    = w_hit_ex && ex_tag.load;
    assign w_unused_loads = mem_tag.load | wb_tag.load;

    always_comb begin
        sel  = SEL_RF;
        data = rf_data;
        if (w_hit_ex) begin
            sel  = SEL_EX;
            data = ex_data;
        end else if (w_hit_mem) begin
            sel  = SEL_MEM;
            data = mem_data;
        end else if (w_hit_wb) begin
            sel  = SEL_WB;
            data = wb_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/forwarding_scoreboard.sv
// ============================================================================
// Module   : forwarding_scoreboard
// Brief    : Tracks EX/MEM/WB destination tags, resolves NUM_SRC decode
//            operands from the youngest producer and raises load-use stalls.
// Options  : FWD_STATS_EN adds 32-bit saturating stall/forward counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module forwarding_scoreboard
    import forwarding_scoreboard_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pipe_hold,
    input  logic                        flush,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [NUM_SRC*DATA_W-1:0]   id_rf_data,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_wr,
    input  logic                        id_load,
    input  logic [DATA_W-1:0]           ex_result,
    input  logic [DATA_W-1:0]           mem_result,
    input  logic [DATA_W-1:0]           wb_result,
    output logic [NUM_SRC*DATA_W-1:0]   src_out,
    output logic [NUM_SRC*2-1:0]        src_sel,
    output logic                        stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 fwd_ex_cnt,
    output logic [31:0]                 fwd_mem_cnt,
    output logic [31:0]                 fwd_wb_cnt
`endif
);

    stage_tag_t           r_ex_tag;
    stage_tag_t           r_mem_tag;
    stage_tag_t           r_wb_tag;
    stage_tag_t           w_ex_next;
    logic [NUM_SRC-1:0]   w_load_hazard;
    logic                 w_stall;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW_MAX-1:0] w_src;

            assign w_src = REG_AW_MAX'(id_src[gi*REG_AW +: REG_AW]);

            fwd_src_resolve #(
                .DATA_W (DATA_W)
            ) u_resolve (
                .src         (w_src),
                .src_used    (id_src_used[gi]),
                .ex_tag      (r_ex_tag),
                .mem_tag     (r_mem_tag),
                .wb_tag      (r_wb_tag),
                .rf_data     (id_rf_data[gi*DATA_W +: DATA_W]),
                .ex_data     (ex_result),
                .mem_data    (mem_result),
                .wb_data     (wb_result),
                .sel         (src_sel[gi*2 +: 2]),
                .data        (src_out[gi*DATA_W +: DATA_W]),
                .load_hazard (w_load_hazard[gi])
            );
        end
    endgenerate

    // A flushed instruction never waits; its slot simply becomes a bubble.
    assign w_stall = id_valid && !flush && (|w_load_hazard);
    assign stall   = w_stall;

    always_comb begin
        w_ex_next = TAG_EMPTY;
        if (id_valid && id_wr && (id_rd != '0) && !w_stall && !flush) begin
            w_ex_next.valid = 1'b1;
            w_ex_next.rd    = REG_AW_MAX'(id_rd);
            w_ex_next.load  = id_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_tag  <= TAG_EMPTY;
            r_mem_tag <= TAG_EMPTY;
            r_wb_tag  <= TAG_EMPTY;
        end else if (!pipe_hold) begin
            r_wb_tag  <= r_mem_tag;
            r_mem_tag <= r_ex_tag;
            r_ex_tag  <= w_ex_next;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_ex_cnt;
    logic [31:0] r_fwd_mem_cnt;
    logic [31:0] r_fwd_wb_cnt;
    logic [31:0] w_n_ex;
    logic [31:0] w_n_mem;
    logic [31:0] w_n_wb;

    // Forwarded source-cycles are counted only while the pipeline advances.
    always_comb begin
        w_n_ex  = '0;
        w_n_mem = '0;
        w_n_wb  = '0;
        if (id_valid && !pipe_hold) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                case (src_sel[i*2 +: 2])
                    SEL_EX:  w_n_ex  = w_n_ex  + 32'd1;
                    SEL_MEM: w_n_mem = w_n_mem + 32'd1;
                    SEL_WB:  w_n_wb  = w_n_wb  + 32'd1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt   <= '0;
            r_fwd_ex_cnt  <= '0;
            r_fwd_mem_cnt <= '0;
            r_fwd_wb_cnt  <= '0;
        end else begin
            if (w_stall && !pipe_hold) begin
                r_stall_cnt <= sat_add32(r_stall_cnt, 32'd1);
            end
            r_fwd_ex_cnt  <= sat_add32(r_fwd_ex_cnt,  w_n_ex);
            r_fwd_mem_cnt <= sat_add32(r_fwd_mem_cnt, w_n_mem);
            r_fwd_wb_cnt  <= sat_add32(r_fwd_wb_cnt,  w_n_wb);
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign fwd_ex_cnt  = r_fwd_ex_cnt;
    assign fwd_mem_cnt = r_fwd_mem_cnt;
    assign fwd_wb_cnt  = r_fwd_wb_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
- Parametrised successor to the pipeline's two-operand redirection mux. Tracks in-flight destination registers for the EX, MEM and WB stages in an internal tag pipeline.
- Resolves NUM_SRC decode-stage operands from the youngest producer and raises a load-use stall when the producer's data is not yet available.
- Sits between ID and the ID/EX latch and replaces the hand-driven 4-bit redirection control.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width; register 0 is hardwired zero
- NUM_SRC, 2, number of decode-stage source operands resolved in parallel

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_hold  in  1  external freeze (memory wait); tag pipeline holds, no bubble inserted
- flush  in  1  branch/exception flush of the instruction in ID
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_SRC*REG_AW  source register numbers, src i at bits [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  per-source "operand actually read"
- id_rf_data  in  NUM_SRC*DATA_W  register-file read data per source
- id_rd  in  REG_AW  destination of the ID instruction
- id_wr  in  1  ID instruction writes id_rd
- id_load  in  1  ID instruction is a load
- ex_result  in  DATA_W  ALU output of the EX stage
- mem_result  in  DATA_W  result of the MEM stage (load data or passed ALU value)
- wb_result  in  DATA_W  write-back data
- src_out  out  NUM_SRC*DATA_W  resolved operands
- src_sel  out  NUM_SRC*2  per-source select: 0 RF, 1 EX, 2 MEM, 3 WB
- stall  out  1  hold PC/IF/ID and insert a bubble into EX

Behaviour:
- Tag pipeline: three slots EX, MEM, WB, each {valid, rd, load}. Reset (rst_n low, asynchronous) clears all valid bits. stall, src_sel and src_out are then 0 and RF data respectively.
- Per rising edge, when pipe_hold=0: WB<=MEM, MEM<=EX.
  - EX<=ID tag if id_valid & id_wr & id_rd!=0 & !stall & !flush.
  - Otherwise EX<=invalid (bubble).
- pipe_hold=1: all slots hold; stall output is still computed but no bubble is inserted.
- Match for source i: id_src_used[i] & id_src[i]!=0 & slot.valid & slot.rd==id_src[i].
- Priority is the youngest producer: EX > MEM > WB > RF. src_sel/src_out are combinational, with zero latency from the ID inputs and the slot state.
- Load-use: if source i matches the EX slot and that slot's load=1, stall=1, ANDed with id_valid & !flush. A load in MEM forwards mem_result without a stall.
- One load-use stall lasts exactly one cycle: the bubble moves the load to MEM on the next edge, and the following cycle forwards from MEM.
- Multiple sources matching different slots are resolved independently.
- A source naming register 0 always selects RF; register 0 is never tracked.
- Flush with a stall pending: stall is deasserted and a bubble enters EX. Older slots continue unaffected.
- Reset mid-stall: the slots clear immediately and stall drops asynchronously.

Optional Feature:
- Macro: FWD_STATS_EN.
- With the macro defined, these 32-bit saturating counters are added, all cleared by reset:
  - stall_cnt: counts cycles with stall=1 & !pipe_hold.
  - fwd_ex_cnt, fwd_mem_cnt, fwd_wb_cnt: count forwarded source-cycles per slot.
  - Exposed as output ports stall_cnt, fwd_ex_cnt, fwd_mem_cnt and fwd_wb_cnt; saturate at 0xFFFF_FFFF.
- Without the macro: no counters and no extra ports; all other behaviour is identical.

Decomposition:
- Shared package:
  - Select encodings SEL_RF=0, SEL_EX=1, SEL_MEM=2, SEL_WB=3.
  - Stage tag struct {valid, rd, load}.
  - Constant REG_ZERO.
- One sub-module, fwd_src_resolve: a single-source comparator, priority and mux taking the three tags, rf/ex/mem/wb data, and producing sel, data and a load_hazard flag. It is instantiated NUM_SRC times via generate.

Test Plan:
- Back-to-back ALU: add r3 issued, next instruction reads r3 with ex_result=0x0000_1234 -> src_sel=1, src_out=0x0000_1234, stall=0.
- Load-use: lw r5 issued, next reads r5 -> stall=1 for one cycle. Next cycle src_sel=2 and src_out=mem_result (e.g. 0xDEAD_BEEF), stall=0.
- Priority: r7 written by the instructions in WB, MEM and EX simultaneously -> src_sel=1 (EX). Retire the EX producer with a bubble behind it -> src_sel becomes 2.
- Register zero: a producer with rd=0 is tracked as invalid, a source reads r0 -> src_sel=0, src_out=id_rf_data.
- Flush and hold:
  - flush during a load-use -> stall=0 and the EX slot is a bubble on the next edge.
  - pipe_hold=1 for 3 cycles -> slot contents unchanged and forwarding results are stable.
- Async reset while the slots are valid and stall=1: stall=0 and src_sel=0 immediately, with no clock edge required. With FWD_STATS_EN, the counters read 0.
